// File: rtl/uart_axi_pkg.sv
// rtl/uart_axi_pkg.sv - shared constants and RX FSM encoding for the UART/AXI bridges
package uart_axi_pkg;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;

    localparam logic [31:0] REG_DATA_OFS   = 32'd0;
    localparam logic [31:0] REG_STAT_OFS   = 32'd4;

    localparam int          STAT_EMPTY_BIT = 31;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/axi4_uart_rx_bridge_if.sv
// rtl/axi4_uart_rx_bridge_if.sv - AXI4 read address/data channel bundle
interface axi4_uart_rx_bridge_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 serial receiver with input synchronizer
module uart_rx_8n1
    import uart_axi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // sync1/sync2 form the synchronizer; sync_prev remembers the previous
    // synchronized sample so IDLE reacts to a true 1->0 edge, not a held-low line
    logic            sync1, sync2, sync_prev;
    rx_state_e       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;

    // Synchronizer and edge-history flops, idle-high out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= uart_rx;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic: half-bit to mid start, then whole bits to each mid-bit sample
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (sync_prev && !sync2) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!sync2) begin
                        state_n   = RX_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n   = RX_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {sync2, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // The stop sample cycle itself reports the frame, so the FIFO sees it one edge later
    always_comb begin
        rx_strobe    = (state == RX_STOP) && (cnt == BIT_LAST);
        rx_byte      = shift;
        rx_frame_err = rx_strobe && !sync2;
    end

endmodule

// File: rtl/axi4_uart_rx_bridge.sv
// rtl/axi4_uart_rx_bridge.sv - AXI4 read-only slave returning received UART bytes
module axi4_uart_rx_bridge
    import uart_axi_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h9000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    axi4_uart_rx_bridge_if.slave  bus
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    logic            rx_strobe;
    logic [7:0]      rx_byte;
    logic            rx_frame_err;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            overrun, frame_err;

    logic            r_valid;
    logic [31:0]     r_data;
    logic [1:0]      r_resp;

    logic            ar_fire, sel_data, sel_stat;
    logic            fifo_empty, fifo_full;
    logic            pop, push_req, push;
    logic            ovr_set, ferr_set, stat_clr;
    logic [7:0]      count8;
    logic [31:0]     resp_data;
    logic [1:0]      resp_code;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .rx_strobe    (rx_strobe),
        .rx_byte      (rx_byte),
        .rx_frame_err (rx_frame_err)
    );

    assign bus.arready = !r_valid;
    assign bus.rvalid  = r_valid;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_resp;

    // Decode and FIFO control; a pop frees the slot a same-cycle push needs
    always_comb begin
        ar_fire    = bus.arvalid && !r_valid;
        sel_data   = (bus.araddr == BASE_ADDR + REG_DATA_OFS);
        sel_stat   = (bus.araddr == BASE_ADDR + REG_STAT_OFS);
        fifo_empty = (count == '0);
        fifo_full  = (count == CNTW'(FIFO_DEPTH));
        pop        = ar_fire && sel_data && !fifo_empty;
        push_req   = rx_strobe && !rx_frame_err;
        push       = push_req && (!fifo_full || pop);
        ovr_set    = push_req && fifo_full && !pop;
        ferr_set   = rx_frame_err;
        stat_clr   = ar_fire && sel_stat;
        count8     = 8'(count);
    end

    // Response word for the address presented at the AR handshake
    always_comb begin
        resp_data = '0;
        resp_code = RESP_OKAY;
        if (sel_data) begin
            if (fifo_empty) begin
                resp_data[STAT_EMPTY_BIT] = 1'b1;
            end else begin
                resp_data = {24'h0, mem[rd_ptr]};
            end
        end else if (sel_stat) begin
            resp_data = {16'h0, count8, 5'h0, frame_err, overrun, !fifo_empty};
        end else begin
            resp_code = RESP_SLVERR;
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // FIFO pointers, occupancy and sticky flags (a set beats a status-read clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNTW'(push) - CNTW'(pop);
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (stat_clr) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (stat_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Single outstanding read: capture at AR handshake, hold until R handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else if (ar_fire) begin
            r_valid <= 1'b1;
            r_data  <= resp_data;
            r_resp  <= resp_code;
        end else if (r_valid && bus.rready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_uart_rx_bridge.sv
// tb/tb_axi4_uart_rx_bridge.sv - scoreboard bench for axi4_uart_rx_bridge
module tb_axi4_uart_rx_bridge;

    localparam int          CPB   = 16;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h9000_0000;

    logic clk;
    logic rst_n;
    logic uart_rx;

    axi4_uart_rx_bridge_if bus ();

    axi4_uart_rx_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: received bytes, sticky flags, expected responses
    logic [7:0]  model_q [$];
    logic        model_ovr;
    logic        model_ferr;
    logic [33:0] exp_q [$];
    int          n_resp;
    int          n_issued;
    int          passed;
    int          total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drive one 8N1 frame; the model learns of it once the whole frame is on the wire
    task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit upd);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = good_stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
        if (upd) begin
            if (!good_stop) begin
                model_ferr = 1'b1;
            end else if (model_q.size() < DEPTH) begin
                model_q.push_back(b);
            end else begin
                model_ovr = 1'b1;
            end
        end
    endtask

    // What a read of address a must return, applying its side effects to the model
    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        if (a == BASE) begin
            if (model_q.size() == 0) begin
                d = 32'h8000_0000;
            end else begin
                d = {24'h0, model_q.pop_front()};
            end
        end else if (a == BASE + 32'd4) begin
            d = {16'h0, 8'(model_q.size()), 5'h0, model_ferr, model_ovr, model_q.size() != 0};
            model_ferr = 1'b0;
            model_ovr  = 1'b0;
        end else begin
            d = 32'h0;
            r = 2'b10;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input bit hold_chk);
        logic [31:0] d;
        logic [1:0]  r;
        bit          ok;
        model_read(a, d, r);
        exp_q.push_back({r, d});
        n_issued++;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("ar_handshake");
        @(posedge clk);
        #2;
        bus.arvalid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (hold_chk) begin
                check("hold_rvalid", 32'(bus.rvalid), 32'd1);
                check("hold_arready", 32'(bus.arready), 32'd0);
                check("hold_rdata", bus.rdata, d);
                check("hold_rresp", 32'(bus.rresp), 32'(r));
            end
        end
        @(posedge clk);
        #2;
        bus.rready = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (n_resp >= n_issued) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("r_handshake");
        #2;
        bus.rready = 1'b0;
    endtask

    // Monitor: every R handshake is compared with the oldest expected response
    always @(negedge clk) begin
        if (rst_n && bus.rvalid && bus.rready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", bus.rdata, 32'hxxxx_xxxx);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("rdata", bus.rdata, e[31:0]);
                check("rresp", 32'(bus.rresp), 32'(e[33:32]));
            end
            n_resp++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, 32'(bus.arready), 32'd1);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
        check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        n_resp      = 0;
        n_issued    = 0;
        model_ovr   = 1'b0;
        model_ferr  = 1'b0;
        uart_rx     = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        do_read(BASE + 32'd4, 0, 0);
        do_read(BASE, 1, 0);

        send_frame(8'hA5, 1, 1);
        send_frame(8'h3C, 1, 1);
        do_read(BASE, 0, 0);
        do_read(BASE, 2, 0);
        do_read(BASE + 32'd4, 0, 0);

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 1);
        do_read(BASE + 32'd4, 0, 0);
        do_read(BASE + 32'd4, 0, 0);
        for (int i = 0; i < 16; i++) do_read(BASE, $urandom_range(0, 2), 0);

        send_frame(8'hE7, 0, 1);
        do_read(BASE + 32'd4, 0, 0);
        send_frame(8'h55, 1, 1);
        do_read(BASE, 0, 0);

        send_frame(8'h9A, 1, 1);
        do_read(BASE + 32'd8, 20, 1);
        do_read(BASE + 32'd4, 0, 0);
        do_read(BASE, 0, 0);

        for (int it = 0; it < 25; it++) begin
            int ns;
            int nr;
            ns = $urandom_range(0, 3);
            for (int k = 0; k < ns; k++) begin
                send_frame(8'($urandom), $urandom_range(0, 7) != 0, 1);
            end
            nr = $urandom_range(1, 4);
            for (int k = 0; k < nr; k++) begin
                case ($urandom_range(0, 4))
                    0, 1:    do_read(BASE, $urandom_range(0, 3), 0);
                    2:       do_read(BASE + 32'd4, $urandom_range(0, 3), 0);
                    3:       do_read(BASE + 32'd8, $urandom_range(0, 3), 0);
                    default: do_read(BASE + 32'd1, $urandom_range(0, 3), 0);
                endcase
            end
        end

        fork
            send_frame(8'hC3, 1, 0);
            begin
                tick(5 * CPB);
                bus.araddr  = BASE + 32'd4;
                bus.arvalid = 1'b1;
                bus.rready  = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #2;
                bus.arvalid = 1'b0;
                @(negedge clk);
                check("pending_rvalid", 32'(bus.rvalid), 32'd1);
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_reset");
            end
        join
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check_reset_outputs("post_reset");
        send_frame(8'h81, 1, 1);
        do_read(BASE, 0, 0);
        do_read(BASE + 32'd4, 0, 0);

        tick(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi4_uart_rx_bridge.md
# axi4_uart_rx_bridge

AXI4 read-only slave that receives 8N1 serial bytes on `uart_rx`, buffers them in a FIFO and returns them to the CPU on the AXI read channel. It is the receive-side counterpart of the UART transmit write bridge. It sits on the same peripheral bus at `BASE_ADDR`: the data register is at `BASE_ADDR+0` and the status register is at `BASE_ADDR+4`.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per UART bit (12 MHz / 115200); must be ≥ 8.
- `FIFO_DEPTH`, 16, RX FIFO entries; power of two, 2..256.
- `BASE_ADDR`, 32'h90000000, address of the data register.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `araddr` in 32: read address.
- `arvalid` in 1: read address valid.
- `arready` out 1: read address ready.
- `rdata` out 32: read data.
- `rresp` out 2: read response; `2'b00` OKAY, `2'b10` SLVERR.
- `rvalid` out 1: read data valid.
- `rready` in 1: read data ready.
- `uart_rx` in 1: serial input; idles high; asynchronous to `clk`.

## Operation
- Reset values: `arready`=1, `rvalid`=0, `rdata`=0, `rresp`=00.
- Reset also clears: FIFO (count 0, pointers 0), sticky flags, RX FSM (IDLE), synchronizer (both flops 1).
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - FSM states and transitions:
    - IDLE → START on a sampled 1→0 edge.
    - START: wait `CLKS_PER_BIT/2`, resample. Low → DATA. High (glitch) → IDLE, no error.
    - DATA: sample 8 bits every `CLKS_PER_BIT`, LSB first.
    - STOP: sample one bit period later.
  - STOP sample high: push the byte. If the FIFO is full, drop the byte and set sticky `overrun`.
  - STOP sample low: discard the byte and set sticky `frame_err`.
  - Either way, STOP → IDLE.
- Read channel:
  - One outstanding transaction. `arready` = !`rvalid`.
  - On the AR handshake the response is registered: `rvalid`=1 next cycle.
  - `rdata`/`rresp` are held stable until `rvalid && rready`. `rvalid` drops that cycle and `arready` rises the same cycle.
- Decode (exact address match; `araddr[1:0]` not ignored):
  - `BASE_ADDR`, FIFO non-empty: `rdata`={24'h0, head byte}, OKAY. Pop at the AR handshake.
  - `BASE_ADDR`, FIFO empty: `rdata`=32'h8000_0000 (bit31 = empty), OKAY, no pop.
  - `BASE_ADDR+4` (status): `rdata`={16'h0, count[7:0], 5'h0, frame_err, overrun, !empty}, OKAY. Both sticky flags clear at this handshake.
  - Any other address: `rdata`=0, SLVERR, no side effects.
- Simultaneous events:
  - Pop and push in the same cycle with the FIFO full: the pop takes effect first, so the push is accepted and `overrun` is not set.
  - Pop and push in the same cycle with the FIFO empty: the read returns empty, and the pushed byte is stored.
  - Sticky-flag set and status-read clear in the same cycle: the set wins.
  - Count arithmetic is `$clog2(FIFO_DEPTH)+1` bits wide; pointers wrap modulo `FIFO_DEPTH`.
- Reset assertion mid-frame or mid-transaction aborts immediately: the byte is lost and `rvalid` drops. After release, RX waits for the next falling edge.

## Timing
- Stop-bit sample to FIFO visible: 1 cycle, i.e. status `!empty` is readable on the next AR.
- `uart_rx` edge to FSM START: 2 cycles (synchronizer latency).
- AR handshake to `rvalid`: 1 cycle.
- Back-to-back reads:
  - With `rready` held high, one transaction every 2 cycles.
  - `arvalid` asserted while `rvalid`=1 waits.
  - `rready` held low stalls indefinitely; RX keeps receiving into the FIFO.
- Frame length: 10×`CLKS_PER_BIT` cycles. The FSM returns to IDLE at mid-stop-bit, so a new start edge is accepted at 9.5 bit times.

## Structure
- Shared package `uart_axi_pkg`:
  - `RESP_OKAY`, `RESP_SLVERR`.
  - `REG_DATA_OFS`=0, `REG_STAT_OFS`=4.
  - `STAT_EMPTY_BIT`=31.
  - RX FSM state encodings.
- Sub-module `uart_rx_8n1`: synchronizer + FSM. Outputs are a one-cycle `rx_strobe`, `rx_byte[7:0]` and `rx_frame_err`.
- The top level owns the FIFO, flags and AXI logic.

## Test plan
- Reset, then read `BASE_ADDR+4` → `rdata`=32'h0000_0000, OKAY. Read `BASE_ADDR` → 32'h8000_0000, OKAY.
- Send 0xA5 then 0x3C serially, then read data twice → 32'h0000_00A5, then 32'h0000_003C. A following status read shows count 0.
- Send 17 bytes (0x00..0x10) without reading, FIFO_DEPTH=16:
  - status → count 16, overrun=1, bit0=1.
  - second status read → overrun=0.
  - reading 16 data words returns 0x00..0x0F.
- Send a frame with the stop bit forced low → status frame_err=1, count 0. Then send 0x55 → read returns 0x55.
- Read `BASE_ADDR+8` → SLVERR, `rdata`=0, FIFO unchanged. Then hold `rready`=0 for 20 cycles → `rvalid`, `rdata`, `rresp` stable and `arready`=0 throughout.
- Assert `rst_n`=0 mid-frame and mid-response → all outputs take their reset values asynchronously. After release, a fresh 0x81 frame is received correctly.
